core_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter that lets the core's instruction fetch port (read-only) and data port share a single memory bus. It sits between the CPU top level and the system memory/interconnect. It grants one transaction at a time and latches the winner's request onto the shared bus. It routes the slave's response back to the winner only. Data accesses have priority, bounded by a fairness counter so that fetch is never starved.

---
 rtl/core_pkg.sv | 28 ++
 rtl/core_arb_fair.sv | 63 ++++++
 rtl/core_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_core_bus_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the core bus arbiter: FSM state encoding and the
// latched shared-bus request payload.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  localparam bus_req_t BUS_REQ_IDLE = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, wstrb: 4'd0};

  // The fetch port is read-only, so its payload never carries write data or strobes.
  function automatic bus_req_t fetch_req(input logic [31:0] addr);
    bus_req_t req;
    req       = BUS_REQ_IDLE;
    req.addr  = addr;
    return req;
  endfunction

endpackage

// File: rtl/core_arb_fair.sv
// Priority decision between fetch and data with a saturating streak counter
// that hands the bus to fetch after DATA_STREAK_MAX consecutive data wins.
module core_arb_fair #(
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [7:0] STREAK_MAX = 8'(DATA_STREAK_MAX);

  logic [7:0] streak_r;
  logic [7:0] streak_nxt_s;
  logic       fetch_due_s;

  // Grant decision and next streak value
  always_comb begin
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    streak_nxt_s = streak_r;
    fetch_due_s  = (streak_r == STREAK_MAX);

    if (arb_en) begin
      if (d_req && !(i_req && fetch_due_s)) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end else begin
        grant_d = 1'b0;
      end
    end else begin
      grant_i = 1'b0;
    end

    // Streak only counts data wins that actually made fetch wait
    if (grant_i) begin
      streak_nxt_s = 8'd0;
    end else if (grant_d) begin
      if (i_req) begin
        streak_nxt_s = (streak_r == 8'hFF) ? streak_r : streak_r + 8'd1;
      end else begin
        streak_nxt_s = 8'd0;
      end
    end else begin
      streak_nxt_s = streak_r;
    end
  end

  // Streak register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_r <= 8'd0;
    end else begin
      streak_r <= streak_nxt_s;
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Two-master (fetch, data) to one-slave bus arbiter: grants one transaction
// at a time, registers the winner's payload and routes the ack to the owner.
module core_bus_arbiter
  import core_pkg::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  arb_state_t state_r;
  arb_state_t state_nxt_s;
  bus_req_t   bus_r;
  bus_req_t   bus_nxt_s;
  logic       m_req_r;
  logic       m_req_nxt_s;
  logic       arb_en_s;
  logic       grant_i_s;
  logic       grant_d_s;

  assign arb_en_s = (state_r == IDLE);

  core_arb_fair #(
    .DATA_STREAK_MAX(DATA_STREAK_MAX)
  ) u_fair (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (arb_en_s),
    .i_req   (i_req),
    .d_req   (d_req),
    .grant_i (grant_i_s),
    .grant_d (grant_d_s)
  );

  // Next state, payload capture and owner ack routing
  always_comb begin
    state_nxt_s = state_r;
    bus_nxt_s   = bus_r;
    m_req_nxt_s = m_req_r;
    i_ack       = 1'b0;
    d_ack       = 1'b0;

    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_nxt_s = OWN_D;
          bus_nxt_s   = '{we: d_we, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
          m_req_nxt_s = 1'b1;
        end else if (grant_i_s) begin
          state_nxt_s = OWN_I;
          bus_nxt_s   = fetch_req(i_addr);
          m_req_nxt_s = 1'b1;
        end else begin
          m_req_nxt_s = 1'b0;
        end
      end
      OWN_I: begin
        if (m_ack) begin
          i_ack       = 1'b1;
          state_nxt_s = IDLE;
          m_req_nxt_s = 1'b0;
        end else begin
          state_nxt_s = OWN_I;
        end
      end
      OWN_D: begin
        if (m_ack) begin
          d_ack       = 1'b1;
          state_nxt_s = IDLE;
          m_req_nxt_s = 1'b0;
        end else begin
          state_nxt_s = OWN_D;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        m_req_nxt_s = 1'b0;
      end
    endcase
  end

  // State, request flag and payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      bus_r   <= BUS_REQ_IDLE;
      m_req_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      bus_r   <= bus_nxt_s;
      m_req_r <= m_req_nxt_s;
    end
  end

  assign m_req   = m_req_r;
  assign m_we    = bus_r.we;
  assign m_addr  = bus_r.addr;
  assign m_wdata = bus_r.wdata;
  assign m_wstrb = bus_r.wstrb;

  // Read data is broadcast; only the acked port treats it as valid
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Scoreboard bench for core_bus_arbiter: predicted grants are queued when
// requests are driven and checked when the shared bus shows each transaction.
module tb_core_bus_arbiter;

  localparam int unsigned STREAK_MAX = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ack;

  typedef struct {
    logic        own_i;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   tb_streak;

  core_bus_arbiter #(.DATA_STREAK_MAX(STREAK_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ack(m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Predict the next grant from the arbitration rule and queue its payload
  task automatic expect_grant(input logic i, input logic d);
    exp_t e;
    if (d && !(i && tb_streak == int'(STREAK_MAX))) begin
      e = '{own_i: 1'b0, we: d_we, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
      tb_streak = i ? ((tb_streak == 255) ? 255 : tb_streak + 1) : 0;
    end else begin
      e = '{own_i: 1'b1, we: 1'b0, addr: i_addr, wdata: 32'd0, wstrb: 4'd0};
      tb_streak = 0;
    end
    exp_q.push_back(e);
  endtask

  // Slave model: wait for m_req, compare payload, ack after lat cycles
  task automatic serve(input int lat, input logic [31:0] rd);
    exp_t e;
    int   n;
    n = 0;
    while (m_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (m_req !== 1'b1) begin
      check_eq("m_req_timeout", 32'(m_req), 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("m_we", 32'(m_we), 32'(e.we));
    check_eq("m_addr", m_addr, e.addr);
    check_eq("m_wdata", m_wdata, e.wdata);
    check_eq("m_wstrb", 32'(m_wstrb), 32'(e.wstrb));
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      check_eq("hold_m_req", 32'(m_req), 32'd1);
      check_eq("hold_m_addr", m_addr, e.addr);
    end
    m_rdata = rd;
    m_ack   = 1'b1;
    #1;
    check_eq("i_ack", 32'(i_ack), 32'(e.own_i));
    check_eq("d_ack", 32'(d_ack), 32'(!e.own_i));
    check_eq("rdata", e.own_i ? i_rdata : d_rdata, rd);
    @(negedge clk);
    m_ack = 1'b0;
    check_eq("m_req_clr", 32'(m_req), 32'd0);
    check_eq("ack_clr", 32'({i_ack, d_ack}), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; tb_streak = 0;
    rst = 1'b1; i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0; m_rdata = 32'd0; m_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_m_req", 32'(m_req), 32'd0);
    check_eq("rst_m_addr", m_addr, 32'd0);
    rst = 1'b0;

    // Reset mid-transaction
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h5000_0000; d_wdata = 32'h0BAD_F00D; d_wstrb = 4'hF;
    @(negedge clk);
    check_eq("pre_rst_m_req", 32'(m_req), 32'd1);
    check_eq("pre_rst_m_we", 32'(m_we), 32'd1);
    rst = 1'b1; m_ack = 1'b1;
    #1;
    check_eq("rst_mid_m_req", 32'(m_req), 32'd0);
    check_eq("rst_mid_m_we", 32'(m_we), 32'd0);
    check_eq("rst_mid_m_wdata", m_wdata, 32'd0);
    check_eq("rst_mid_acks", 32'({i_ack, d_ack}), 32'd0);
    @(negedge clk);
    rst = 1'b0; m_ack = 1'b0; d_req = 1'b0; d_we = 1'b0; tb_streak = 0;
    i_req = 1'b1; i_addr = 32'h1000_0000;
    expect_grant(1'b1, 1'b0);
    @(negedge clk);
    check_eq("post_rst_lat", 32'(m_req), 32'd1);
    serve(2, 32'hCAFE_0001);
    i_req = 1'b0;

    // Single fetch, 3-cycle slave
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h1000_0004;
    expect_grant(1'b1, 1'b0);
    @(negedge clk);
    check_eq("fetch_lat", 32'(m_req), 32'd1);
    serve(3, 32'hDEAD_BEEF);
    i_req = 1'b0;

    // Simultaneous requests: data first, then fetch
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h1000_0008;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000_0000; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    expect_grant(1'b1, 1'b1);
    expect_grant(1'b1, 1'b0);
    serve(2, 32'h0000_00D1);
    d_req = 1'b0;
    serve(2, 32'h0000_00F1);
    i_req = 1'b0;

    // Payload isolation: inputs change and d_req drops mid-transaction
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6000_0000; d_wdata = 32'hAAAA_5555; d_wstrb = 4'h3;
    expect_grant(1'b0, 1'b1);
    @(negedge clk);
    d_req = 1'b0; d_addr = 32'h7000_0000; d_wdata = 32'd0; d_we = 1'b0;
    serve(4, 32'h0000_1501);

    // Spurious ack in IDLE
    @(negedge clk);
    m_ack = 1'b1;
    #1;
    check_eq("spur_acks", 32'({i_ack, d_ack}), 32'd0);
    @(negedge clk);
    check_eq("spur_m_req", 32'(m_req), 32'd0);
    check_eq("spur_acks2", 32'({i_ack, d_ack}), 32'd0);
    m_ack = 1'b0;
    i_req = 1'b1; i_addr = 32'h1000_0010;
    expect_grant(1'b1, 1'b0);
    @(negedge clk);
    check_eq("spur_idle_lat", 32'(m_req), 32'd1);
    serve(1, 32'h5150_0001);
    i_req = 1'b0;

    // Fairness under continuous contention, 1-cycle slave
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h3000_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000_0000; d_wdata = 32'd0; d_wstrb = 4'd0;
    for (int g = 0; g < 10; g++) expect_grant(1'b1, 1'b1);
    for (int g = 0; g < 10; g++) serve(1, 32'hF000_0000 + 32'(g));
    i_req = 1'b0; d_req = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
